data_ram_resp: RTL and testbench

Data-memory responder sitting on the far side of the pipeline's memory-access stage. Accepts one word-wide load or store request at a time from the initiator, inserts a configurable number of wait states, performs the access on an internal word array with byte-lane enables, and returns a single-cycle acknowledge with read data. Serves as the backing store the access stage talks to during loads and stores.

---
 rtl/data_ram_resp_if.sv | 49 ++++
 rtl/data_ram_resp.sv | 151 +++++++++++++++
 tb/tb_data_ram_resp.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_ram_resp_if.sv
// ---------------------------------------------------------------------------
// data_ram_resp_if
//   Request/response bundle between the memory-access stage (master) and the
//   data RAM responder (slave).
//
//   mem_ce_i   : request valid, held by the master until mem_ack_o
//   mem_we_i   : 1 = store, 0 = load
//   mem_addr_i : byte address (bits [1:0] ignored)
//   mem_sel_i  : byte-lane enables for stores
//   mem_data_i : store data
//   mem_data_o : load data, valid with mem_ack_o on a load
//   mem_ack_o  : one-cycle completion pulse
//   mem_busy_o : request accepted but not yet acknowledged
//   mem_err_o  : out-of-range access flag, only when DRAM_RANGE_CHECK_EN is
//                defined
// ---------------------------------------------------------------------------
interface data_ram_resp_if;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        mem_ack_o;
  logic        mem_busy_o;
`ifdef DRAM_RANGE_CHECK_EN
  logic        mem_err_o;

  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_busy_o, mem_err_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_busy_o, mem_err_o
  );
`else
  modport master (
    output mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_data_o, mem_ack_o, mem_busy_o
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_data_o, mem_ack_o, mem_busy_o
  );
`endif
endinterface

// File: rtl/data_ram_resp.sv
// ---------------------------------------------------------------------------
// data_ram_resp
//   Word-wide data memory behind the pipeline's memory-access stage. Accepts
//   one load/store at a time, inserts WAIT_CYCLES wait states, then returns a
//   single-cycle acknowledge. Stores honour byte-lane enables and commit on
//   the edge leaving the acknowledge cycle; loads return the whole word.
//
//   Parameters
//     DEPTH_LOG2  : log2 of the word count (1..29)
//     WAIT_CYCLES : wait states between acceptance and acknowledge (0..15)
//
//   Ports
//     clk  : clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : data_ram_resp_if.slave request/response bundle
//
//   Build option
//     DRAM_RANGE_CHECK_EN : adds bus.mem_err_o; accesses with nonzero address
//                           bits above the array are flagged, stores are
//                           suppressed and loads return zero. Without it the
//                           upper address bits are ignored and addresses wrap.
// ---------------------------------------------------------------------------
module data_ram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  data_ram_resp_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Counter value loaded on acceptance; the WAIT state runs until it hits 0.
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [3:0]              sel_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic                    err_q;

  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    addr_oob;
  logic                    wr_en;
  logic [31:0]             rd_word;

  assign accept = (state_q == S_IDLE) && bus.mem_ce_i;

`ifdef DRAM_RANGE_CHECK_EN
  assign addr_oob = |bus.mem_addr_i[31:DEPTH_LOG2+2];
  logic unused_addr;
  assign unused_addr = ^bus.mem_addr_i[1:0];
`else
  // Upper address bits are dropped, so accesses alias modulo the array size.
  assign addr_oob = 1'b0;
  logic unused_addr;
  assign unused_addr = ^{bus.mem_addr_i[1:0], bus.mem_addr_i[31:DEPTH_LOG2+2]};
`endif

  // ---------------------------------------------------------------- FSM
  // NOTE: state and every other flop use non-blocking assignments so all
  // registers update together from the values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mem_ce_i) state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
      end
      S_WAIT: begin
        // A withdrawn request abandons the access even on its last wait cycle.
        if (!bus.mem_ce_i)      state_d = S_IDLE;
        else if (cnt_q == 4'd0) state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------ request latch / counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt_q   <= CNT_INIT;
      we_q    <= bus.mem_we_i;
      idx_q   <= bus.mem_addr_i[DEPTH_LOG2+1:2];
      sel_q   <= bus.mem_sel_i;
      wdata_q <= bus.mem_data_i;
      err_q   <= addr_oob;
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // -------------------------------------------------------------- array
  // Loads are served combinationally from the latched index during ACK, so the
  // word is already on mem_data_o while the acknowledge is high.
  assign rd_word = err_q ? 32'd0 : mem[idx_q];

  // Reset in the ACK cycle discards the pending store.
  assign wr_en = (state_q == S_ACK) && we_q && !err_q && !rst;

  // NOTE: the array has no reset; clearing it would defeat RAM inference and
  // software never relies on its power-up contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  // Load data is captured as the ACK cycle ends and held through stores and
  // idle periods until the next load completes.
  always_ff @(posedge clk) begin
    if (rst)                              rdata_q <= 32'd0;
    else if (state_q == S_ACK && !we_q)   rdata_q <= rd_word;
  end

  // -------------------------------------------------------------- outputs
  assign bus.mem_ack_o  = (state_q == S_ACK);
  assign bus.mem_busy_o = (state_q == S_WAIT) || (state_q == S_ACK);
  assign bus.mem_data_o = (state_q == S_ACK && !we_q) ? rd_word : rdata_q;
`ifdef DRAM_RANGE_CHECK_EN
  assign bus.mem_err_o  = (state_q == S_ACK) && err_q;
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// ---------------------------------------------------------------------------
// tb_data_ram_resp
//   Bench for data_ram_resp. Three instances with WAIT_CYCLES = 0, 1 and 3
//   share clock and reset. Each issued request pushes its expected response
//   (data, error flag, acknowledge cycle) into a per-instance queue; a monitor
//   per instance pops and compares on every acknowledge. Honours
//   DRAM_RANGE_CHECK_EN for the out-of-range address case.
// ---------------------------------------------------------------------------
module tb_data_ram_resp;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    bit          err;
    int          cyc;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q3[$];

  data_ram_resp_if if_w0 ();
  data_ram_resp_if if_w1 ();
  data_ram_resp_if if_w3 ();

  data_ram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rst(rst), .bus(if_w0));
  data_ram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .rst(rst), .bus(if_w1));
  data_ram_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_w3 (.clk(clk), .rst(rst), .bus(if_w3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // ------------------------------------------------ per-instance accessors
  // The instance id equals its WAIT_CYCLES value.
  task automatic set_req(input int id, input logic ce, input logic we, input logic [31:0] addr,
                         input logic [3:0] sel, input logic [31:0] wdata);
    case (id)
      0: begin if_w0.mem_ce_i = ce; if_w0.mem_we_i = we; if_w0.mem_addr_i = addr;
               if_w0.mem_sel_i = sel; if_w0.mem_data_i = wdata; end
      1: begin if_w1.mem_ce_i = ce; if_w1.mem_we_i = we; if_w1.mem_addr_i = addr;
               if_w1.mem_sel_i = sel; if_w1.mem_data_i = wdata; end
      default: begin if_w3.mem_ce_i = ce; if_w3.mem_we_i = we; if_w3.mem_addr_i = addr;
               if_w3.mem_sel_i = sel; if_w3.mem_data_i = wdata; end
    endcase
  endtask

  task automatic set_ce(input int id, input logic ce);
    case (id)
      0:       if_w0.mem_ce_i = ce;
      1:       if_w1.mem_ce_i = ce;
      default: if_w3.mem_ce_i = ce;
    endcase
  endtask

  function automatic logic get_ack(input int id);
    case (id)
      0:       return if_w0.mem_ack_o;
      1:       return if_w1.mem_ack_o;
      default: return if_w3.mem_ack_o;
    endcase
  endfunction

  task automatic push_exp(input int id, input exp_t x);
    case (id)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q3.push_back(x);
    endcase
  endtask

  // --------------------------------------------------------------- driver
  // Presents a request at a falling edge, holds it until the acknowledge is
  // seen and drops mem_ce_i in the acknowledge cycle.
  task automatic do_req(input int id, input bit we, input logic [31:0] addr, input logic [3:0] sel,
                        input logic [31:0] wdata, input logic [31:0] exp_data, input bit exp_err,
                        input string name);
    exp_t x;
    bit   acked;
    @(negedge clk);
    x.data     = exp_data;
    x.chk_data = !we;
    x.err      = exp_err;
    x.cyc      = cyc + id + 1;
    x.name     = name;
    push_exp(id, x);
    set_req(id, 1'b1, we, addr, sel, wdata);
    acked = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (get_ack(id) === 1'b1) begin
        acked = 1'b1;
        break;
      end
    end
    set_ce(id, 1'b0);
    if (!acked) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: no ack within 40 cycles on dut w%0d", name, id);
    end
  endtask

  // -------------------------------------------------------------- monitor
  task automatic mon(input int id, input logic ack, input logic [31:0] d, input logic e);
    exp_t x;
    bit   have;
    if (ack !== 1'b1) return;
    have = 1'b0;
    case (id)
      0:       if (q0.size() > 0) begin x = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin x = q1.pop_front(); have = 1'b1; end
      default: if (q3.size() > 0) begin x = q3.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL unexpected_ack: dut w%0d acked at cycle %0d with nothing outstanding", id, cyc);
      return;
    end
    check({x.name, "_ack_cycle"}, 32'(cyc), 32'(x.cyc));
    if (x.chk_data) check({x.name, "_data"}, d, x.data);
`ifdef DRAM_RANGE_CHECK_EN
    check({x.name, "_err"}, {31'd0, e}, {31'd0, x.err});
`else
    if (e !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL %s_err: got %b expected 0", x.name, e);
    end
`endif
  endtask

`ifdef DRAM_RANGE_CHECK_EN
  always @(negedge clk) mon(0, if_w0.mem_ack_o, if_w0.mem_data_o, if_w0.mem_err_o);
  always @(negedge clk) mon(1, if_w1.mem_ack_o, if_w1.mem_data_o, if_w1.mem_err_o);
  always @(negedge clk) mon(3, if_w3.mem_ack_o, if_w3.mem_data_o, if_w3.mem_err_o);
`else
  always @(negedge clk) mon(0, if_w0.mem_ack_o, if_w0.mem_data_o, 1'b0);
  always @(negedge clk) mon(1, if_w1.mem_ack_o, if_w1.mem_data_o, 1'b0);
  always @(negedge clk) mon(3, if_w3.mem_ack_o, if_w3.mem_data_o, 1'b0);
`endif

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    set_req(3, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_busy",  {31'd0, if_w1.mem_busy_o}, 32'd0);
    check("rst_ack",   {31'd0, if_w1.mem_ack_o},  32'd0);
    check("rst_data",  if_w1.mem_data_o,          32'd0);
`ifdef DRAM_RANGE_CHECK_EN
    check("rst_err",   {31'd0, if_w1.mem_err_o},  32'd0);
`endif

    // WAIT_CYCLES = 1: full-word store then load.
    do_req(1, 1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0,         1'b0, "w1_st_10");
    do_req(1, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0, "w1_ld_10");
    // Load data holds across a store.
    do_req(1, 1'b1, 32'h0000_0014, 4'b1111, 32'h0000_0000, 32'h0,         1'b0, "w1_st_14");
    check("w1_hold_over_store", if_w1.mem_data_o, 32'hDEAD_BEEF);

    // Partial store with lanes 0 and 2.
    do_req(1, 1'b1, 32'h0000_0020, 4'b1111, 32'h1122_3344, 32'h0,         1'b0, "w1_st_20_full");
    do_req(1, 1'b1, 32'h0000_0020, 4'b0101, 32'hAABB_CCDD, 32'h0,         1'b0, "w1_st_20_part");
    do_req(1, 1'b0, 32'h0000_0020, 4'b0000, 32'h0,         32'h11BB_33DD, 1'b0, "w1_ld_20");
    // sel = 0000 store is acknowledged but writes nothing.
    do_req(1, 1'b1, 32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, 32'h0,         1'b0, "w1_st_20_none");
    do_req(1, 1'b0, 32'h0000_0020, 4'b1111, 32'h0,         32'h11BB_33DD, 1'b0, "w1_ld_20_again");

    // Out-of-range / aliasing address 0x1004.
    do_req(1, 1'b1, 32'h0000_0004, 4'b1111, 32'h0102_0304, 32'h0,         1'b0, "w1_st_004");
`ifdef DRAM_RANGE_CHECK_EN
    do_req(1, 1'b1, 32'h0000_1004, 4'b1111, 32'h55AA_55AA, 32'h0,         1'b1, "w1_st_1004_err");
    do_req(1, 1'b0, 32'h0000_1004, 4'b0000, 32'h0,         32'h0000_0000, 1'b1, "w1_ld_1004_err");
    do_req(1, 1'b0, 32'h0000_0004, 4'b0000, 32'h0,         32'h0102_0304, 1'b0, "w1_ld_004");
`else
    do_req(1, 1'b1, 32'h0000_1004, 4'b1111, 32'h55AA_55AA, 32'h0,         1'b0, "w1_st_1004_alias");
    do_req(1, 1'b0, 32'h0000_0004, 4'b0000, 32'h0,         32'h55AA_55AA, 1'b0, "w1_ld_004");
    do_req(1, 1'b0, 32'h0000_1004, 4'b0000, 32'h0,         32'h55AA_55AA, 1'b0, "w1_ld_1004");
`endif

    // WAIT_CYCLES = 3: abort during the second wait cycle.
    do_req(3, 1'b1, 32'h0000_0030, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0, "w3_st_30");
    @(negedge clk);
    set_req(3, 1'b1, 1'b1, 32'h0000_0030, 4'b1111, 32'h1234_5678);
    @(negedge clk);                           // first wait cycle
    check("w3_busy_wait1", {31'd0, if_w3.mem_busy_o}, 32'd1);
    @(negedge clk);                           // second wait cycle
    check("w3_busy_wait2", {31'd0, if_w3.mem_busy_o}, 32'd1);
    set_ce(3, 1'b0);
    @(negedge clk);
    check("w3_abort_idle", {31'd0, if_w3.mem_busy_o}, 32'd0);
    repeat (6) @(negedge clk);                // any ack here is flagged by the monitor
    do_req(3, 1'b0, 32'h0000_0030, 4'b0000, 32'h0,         32'hCAFE_F00D, 1'b0, "w3_ld_30_after_abort");

    // WAIT_CYCLES = 3: reset while waiting discards the store.
    @(negedge clk);
    set_req(3, 1'b1, 1'b1, 32'h0000_0030, 4'b1111, 32'h9999_9999);
    @(negedge clk);
    check("w3_busy_before_rst", {31'd0, if_w3.mem_busy_o}, 32'd1);
    rst = 1'b1;
    set_ce(3, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("w3_rst_busy", {31'd0, if_w3.mem_busy_o}, 32'd0);
    check("w3_rst_ack",  {31'd0, if_w3.mem_ack_o},  32'd0);
    check("w3_rst_data", if_w3.mem_data_o,          32'd0);
    do_req(3, 1'b0, 32'h0000_0030, 4'b0000, 32'h0,         32'hCAFE_F00D, 1'b0, "w3_ld_30_after_rst");

    // WAIT_CYCLES = 0: back-to-back accesses, one idle cycle between acks.
    do_req(0, 1'b1, 32'h0000_0040, 4'b1111, 32'h0BAD_F00D, 32'h0,         1'b0, "w0_st_40");
    do_req(0, 1'b1, 32'h0000_0044, 4'b1111, 32'h600D_CAFE, 32'h0,         1'b0, "w0_st_44");
    do_req(0, 1'b0, 32'h0000_0040, 4'b0000, 32'h0,         32'h0BAD_F00D, 1'b0, "w0_ld_40");
    do_req(0, 1'b0, 32'h0000_0044, 4'b0000, 32'h0,         32'h600D_CAFE, 1'b0, "w0_ld_44");
    do_req(0, 1'b0, 32'h0000_0040, 4'b0000, 32'h0,         32'h0BAD_F00D, 1'b0, "w0_ld_40_again");

    repeat (4) @(negedge clk);
    check("sb_drain_w0", 32'(q0.size()), 32'd0);
    check("sb_drain_w1", 32'(q1.size()), 32'd0);
    check("sb_drain_w3", 32'(q3.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
